// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: sync + glitch filter, frame check, timeout, show-ahead byte FIFO.
// Push lands 2 cycles after the stop-bit clock event; a push into a full FIFO without a same-cycle rd is dropped and sets the sticky overflow flag.
module ps2_rx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_MS = 20,
    parameter int FILTER     = 4,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ps_clock,
    input  logic                  ps_data,
    input  logic                  rd,
    output logic [7:0]            data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  err_parity,
    output logic                  err_frame,
    output logic                  err_timeout,
    input  logic                  clr_err
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int DEPTH       = 1 << DEPTH_LOG2;
    localparam int CW          = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    // index 0 = PS/2 clock line, index 1 = PS/2 data line
    logic [1:0] sync1, sync2, filt;
    logic [3:0] fcnt [2];
    logic       filt_clk_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '1;
            sync2      <= '1;
            filt       <= '1;
            filt_clk_q <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt[i] <= '0;
        end else begin
            sync1      <= {ps_data, ps_clock};
            sync2      <= sync1;
            filt_clk_q <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == 4'(FILTER - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    logic fall, bit_in;
    assign fall   = filt_clk_q & ~filt[0];
    assign bit_in = filt[1];

    state_t          state, state_nxt;
    logic [9:0]      shreg;
    logic [3:0]      bitcnt;
    logic [TW-1:0]   timer;
    logic            push, perr, ferr, terr;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        perr      = 1'b0;
        ferr      = 1'b0;
        terr      = 1'b0;
        case (state)
            IDLE: if (fall && !bit_in) state_nxt = RECV;
            RECV: begin
                if (fall) begin
                    if (bitcnt == 4'd9) state_nxt = CHECK;
                end else if (timer == TW'(TIMEOUT_CYC)) begin
                    state_nxt = IDLE;
                    terr      = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                // odd parity: data bits plus parity bit must hold an odd number of ones
                if (!(^shreg[8:0]))  perr = 1'b1;
                else if (!shreg[9])  ferr = 1'b1;
                else                 push = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            timer       <= '0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_parity  <= perr;
            err_frame   <= ferr;
            err_timeout <= terr;
            if (state == RECV) begin
                if (fall) begin
                    shreg  <= {bit_in, shreg[9:1]};
                    bitcnt <= bitcnt + 4'd1;
                    timer  <= '0;
                end else begin
                    timer  <= timer + TW'(1);
                end
            end else begin
                bitcnt <= '0;
                timer  <= '0;
            end
        end
    end

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, pop, wr_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rd && !empty;
    assign wr_ok = push && (!full || pop);
    assign data  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr] <= shreg[7:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)   rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (wr_ok && !pop)      count <= count + CW'(1);
            else if (!wr_ok && pop) count <= count - CW'(1);
            // a dropped byte in the same cycle as clr_err keeps the flag set
            if (push && !wr_ok)     overflow <= 1'b1;
            else if (clr_err)       overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame-level stimulus against a queue-based FIFO/error model, checked every cycle.
module tb_ps2_rx_fifo;

    localparam int F      = 4;
    localparam int DL     = 3;
    localparam int DEPTH  = 8;
    localparam int CLK_HZ = 50000;
    localparam int TMS    = 4;
    localparam int N      = CLK_HZ / 1000 * TMS;

    logic clock = 0, reset_n = 0, ps_clock = 1, ps_data = 1, rd = 0, clr_err = 0;
    logic [7:0]  data;
    logic        empty, overflow, err_parity, err_frame, err_timeout;
    logic [DL:0] count;

    ps2_rx_fifo #(.CLK_HZ(CLK_HZ), .TIMEOUT_MS(TMS), .FILTER(F), .DEPTH_LOG2(DL)) dut (
        .clock(clock), .reset_n(reset_n), .ps_clock(ps_clock), .ps_data(ps_data),
        .rd(rd), .data(data), .empty(empty), .count(count), .overflow(overflow),
        .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout),
        .clr_err(clr_err)
    );

    always #5 clock = ~clock;

    int checks = 0, failures = 0, cyc = 0;
    bit rd_en = 0, clr_en = 0, rd_manual = 0, clr_manual = 0;
    int rd_div = 4;

    // outcomes scheduled by the stimulus: kind 0 push, 1 parity err, 2 frame err, 3 timeout
    int         ev_at[$];
    int         ev_kind[$];
    logic [7:0] ev_byte[$];
    int         ev_rd = 0;

    logic [7:0] mq[$];
    bit m_ovf = 0, m_ep = 0, m_ef = 0, m_et = 0;

    bit    lit_on = 0;
    int    lit_cnt, lit_dat, lit_ovf;
    string lit_name;
    int    last_fall;

    initial forever begin
        @(posedge clock);
        #2;
        rd      = rd_manual | (rd_en && ($urandom_range(0, rd_div - 1) == 0));
        clr_err = clr_manual | (clr_en && ($urandom_range(0, 31) == 0));
    end

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_ovf = 0; m_ep = 0; m_ef = 0; m_et = 0;
            ev_rd = ev_at.size();
        end else begin
            bit push, pop, dopush;
            logic [7:0] pb;
            push = 0; pb = 8'h00;
            m_ep = 0; m_ef = 0; m_et = 0;
            while (ev_rd < ev_at.size() && ev_at[ev_rd] <= cyc) begin
                if (ev_at[ev_rd] == cyc) begin
                    case (ev_kind[ev_rd])
                        0: begin push = 1; pb = ev_byte[ev_rd]; end
                        1: m_ep = 1;
                        2: m_ef = 1;
                        default: m_et = 1;
                    endcase
                end
                ev_rd++;
            end
            pop    = rd && (mq.size() > 0);
            dopush = push && ((mq.size() < DEPTH) || pop);
            if (pop)    void'(mq.pop_front());
            if (dopush) mq.push_back(pb);
            if (push && !dopush) m_ovf = 1;
            else if (clr_err)    m_ovf = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    initial forever begin
        @(negedge clock);
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("count", 32'(count), mq.size());
        if (mq.size() > 0) chk("data", 32'(data), 32'(mq[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("err_parity", 32'(err_parity), 32'(m_ep));
        chk("err_frame", 32'(err_frame), 32'(m_ef));
        chk("err_timeout", 32'(err_timeout), 32'(m_et));
        if (lit_on) begin
            if (lit_cnt >= 0) chk({lit_name, "_count"}, 32'(count), lit_cnt);
            if (lit_dat >= 0) chk({lit_name, "_data"}, 32'(data), lit_dat);
            if (lit_ovf >= 0) chk({lit_name, "_ovf"}, 32'(overflow), lit_ovf);
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic lit(input string nm, input int c, input int d, input int o);
        lit_name = nm; lit_cnt = c; lit_dat = d; lit_ovf = o; lit_on = 1;
        @(negedge clock);
        #1 lit_on = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic pop1();
        rd_manual = 1; tick(1);
        rd_manual = 0; tick(1);
    endtask

    task automatic sched(input int at, input int kind, input logic [7:0] b);
        ev_at.push_back(at); ev_kind.push_back(kind); ev_byte.push_back(b);
    endtask

    // outcome becomes visible F+4 cycles after the pin edge: 2 sync flops, F filter samples, event->CHECK->register
    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop,
                              input int nbits, input int glitch_bit, input bit rd_at_push);
        logic [10:0] fr;
        int h;
        h  = $urandom_range(F + 5, F + 9);
        fr = {stop, par_ok ? ~^b : ^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps_data = fr[i];
            tick(h);
            if (i == glitch_bit) begin
                ps_clock = 0; tick(2); ps_clock = 1; tick(h);
            end
            ps_clock  = 0;
            last_fall = cyc;
            if (i == 10) sched(last_fall + F + 4, !par_ok ? 1 : (!stop ? 2 : 0), b);
            else if (i == nbits - 1) sched(last_fall + F + 4 + N, 3, 8'h00);
            if (i == 10 && rd_at_push) begin
                tick(F + 3); rd_manual = 1; tick(1); rd_manual = 0; tick(h - F - 4);
            end else begin
                tick(h);
            end
            ps_clock = 1;
        end
        tick(h);
        ps_data = 1;
        tick(h);
    endtask

    initial begin
        tick(3);
        lit("reset", 0, 0, 0);
        reset_n = 1;
        tick(5);

        send_frame(8'h1C, 1, 1, 11, -1, 0);
        lit("t1", 1, 8'h1C, 0);
        pop1();
        lit("t1_rd", 0, -1, 0);

        send_frame(8'h1C, 0, 1, 11, -1, 0);
        send_frame(8'h5A, 1, 0, 11, -1, 0);
        lit("t2", 0, -1, 0);

        send_frame(8'hA5, 1, 1, 5, -1, 0);
        tick(N + 40);
        send_frame(8'hF0, 1, 1, 11, -1, 0);
        lit("t3", 1, 8'hF0, 0);
        pop1();

        ps_clock = 0; tick(2); ps_clock = 1; tick(10);
        send_frame(8'h12, 1, 1, 11, 4, 0);
        lit("t4", 1, 8'h12, 0);
        pop1();

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1, 1, 11, -1, 0);
        lit("t5_full", 8, 1, 1);
        for (int i = 1; i <= 8; i++) begin
            lit("t5_rd", 9 - i, i, 1);
            pop1();
        end
        lit("t5_empty", 0, -1, 1);
        clr_manual = 1; tick(1); clr_manual = 0; tick(1);
        lit("t5_clr", 0, -1, 0);

        for (int i = 1; i <= 8; i++) send_frame(8'(8'h40 + i), 1, 1, 11, -1, 0);
        send_frame(8'h49, 1, 1, 11, -1, 1);
        lit("full_rdpush", 8, 8'h42, 0);
        for (int i = 0; i < 8; i++) pop1();

        send_frame(8'h77, 1, 1, 11, -1, 0);
        send_frame(8'hAA, 1, 1, 5, -1, 0);
        reset_n = 0;
        lit("t6_reset", 0, 0, 0);
        tick(3);
        reset_n = 1;
        tick(5);
        send_frame(8'h33, 1, 1, 11, -1, 0);
        lit("t6", 1, 8'h33, 0);
        pop1();

        rd_en = 1; clr_en = 1;
        for (int k = 0; k < 60; k++) begin
            int e, g;
            rd_div = (k < 30) ? 4 : 300;
            e = $urandom_range(0, 9);
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
            if (e == 2) begin
                send_frame(8'($urandom), 1, 1, $urandom_range(1, 10), g, 0);
                tick(N + 20);
            end else begin
                send_frame(8'($urandom), e != 0, e != 1, 11, g, $urandom_range(0, 4) == 0);
            end
        end
        rd_en = 0; clr_en = 0;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
